// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    localparam int VEDIC_LAT = 4;

    // Operand width must be a power of two in 8..64 so the quadrant recursion bottoms out at 2x2.
    function automatic bit vedic_width_ok(input int w);
        return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_half_mul.sv
// Combinational HWxHW Urdhva-Tiryagbhyam multiplier; splits into four quadrants down to a 2x2 cell.
module vedic_half_mul #(
    parameter int HW = 16
) (
    input  logic [HW-1:0]   i_a,
    input  logic [HW-1:0]   i_b,
    output logic [2*HW-1:0] o_p
);

    if (HW == 2) begin : g_base
        logic       w_p0;
        logic [1:0] w_s1;
        logic [1:0] w_s2;

        // Vertical, crosswise, vertical with the crosswise carry rippling into the top pair.
        assign w_p0 = i_a[0] & i_b[0];
        assign w_s1 = {1'b0, i_a[1] & i_b[0]} + {1'b0, i_a[0] & i_b[1]};
        assign w_s2 = {1'b0, i_a[1] & i_b[1]} + {1'b0, w_s1[1]};
        assign o_p  = {w_s2, w_s1[0], w_p0};
    end else begin : g_rec
        localparam int H = HW / 2;

        logic [HW-1:0] w_ll;
        logic [HW-1:0] w_hl;
        logic [HW-1:0] w_lh;
        logic [HW-1:0] w_hh;
        logic [HW:0]   w_cross;

        vedic_half_mul #(.HW(H)) u_ll (.i_a(i_a[H-1:0]),  .i_b(i_b[H-1:0]),  .o_p(w_ll));
        vedic_half_mul #(.HW(H)) u_hl (.i_a(i_a[HW-1:H]), .i_b(i_b[H-1:0]),  .o_p(w_hl));
        vedic_half_mul #(.HW(H)) u_lh (.i_a(i_a[H-1:0]),  .i_b(i_b[HW-1:H]), .o_p(w_lh));
        vedic_half_mul #(.HW(H)) u_hh (.i_a(i_a[HW-1:H]), .i_b(i_b[HW-1:H]), .o_p(w_hh));

        assign w_cross = {1'b0, w_hl} + {1'b0, w_lh};
        assign o_p     = {w_hh, w_ll} + {{(H-1){1'b0}}, w_cross, {H{1'b0}}};
    end

endmodule

// File: rtl/vedic_mul_pipe.sv
// Four-stage signed/unsigned Vedic multiplier with valid/ready flow control and a sideband tag.
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    if (!vedic_width_ok(WIDTH)) begin : g_bad_width
        $error("vedic_mul_pipe: WIDTH must be a power of two in 8..64");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("vedic_mul_pipe: TAG_W must be at least 1");
    end

    // Two's-complement magnitude; the most negative value maps onto 2^(WIDTH-1) unchanged.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? ((~x) + WIDTH'(1)) : x;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag, input logic neg);
        return neg ? ((~mag) + PW'(1)) : mag;
    endfunction

    logic               w_adv;

    logic               r_vld_p1;
    logic               r_neg_p1;
    logic [TAG_W-1:0]   r_tag_p1;
    logic [WIDTH-1:0]   r_a_p1;
    logic [WIDTH-1:0]   r_b_p1;

    logic [WIDTH-1:0]   w_ll;
    logic [WIDTH-1:0]   w_hl;
    logic [WIDTH-1:0]   w_lh;
    logic [WIDTH-1:0]   w_hh;

    logic               r_vld_p2;
    logic               r_neg_p2;
    logic [TAG_W-1:0]   r_tag_p2;
    logic [WIDTH-1:0]   r_ll_p2;
    logic [WIDTH-1:0]   r_hl_p2;
    logic [WIDTH-1:0]   r_lh_p2;
    logic [WIDTH-1:0]   r_hh_p2;

    logic [WIDTH+1:0]   w_mid;

    logic               r_vld_p3;
    logic               r_neg_p3;
    logic [TAG_W-1:0]   r_tag_p3;
    logic [WIDTH+1:0]   r_mid_p3;
    logic [H-1:0]       r_llo_p3;
    logic [WIDTH-1:0]   r_hh_p3;

    logic [WIDTH-1:0]   w_upper;
    logic [PW-1:0]      w_mag;
    logic [PW-1:0]      w_prod;

    logic               r_out_valid;
    logic [PW-1:0]      r_out_p;
    logic [TAG_W-1:0]   r_out_tag;

    // A single advance enable freezes every stage together, so nothing is dropped under backpressure.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    vedic_half_mul #(.HW(H)) u_mul_ll (.i_a(r_a_p1[H-1:0]),     .i_b(r_b_p1[H-1:0]),     .o_p(w_ll));
    vedic_half_mul #(.HW(H)) u_mul_hl (.i_a(r_a_p1[WIDTH-1:H]), .i_b(r_b_p1[H-1:0]),     .o_p(w_hl));
    vedic_half_mul #(.HW(H)) u_mul_lh (.i_a(r_a_p1[H-1:0]),     .i_b(r_b_p1[WIDTH-1:H]), .o_p(w_lh));
    vedic_half_mul #(.HW(H)) u_mul_hh (.i_a(r_a_p1[WIDTH-1:H]), .i_b(r_b_p1[WIDTH-1:H]), .o_p(w_hh));

    assign w_mid   = {2'b00, r_hl_p2} + {2'b00, r_lh_p2} + {{(H+2){1'b0}}, r_ll_p2[WIDTH-1:H]};
    assign w_upper = r_hh_p3 + {{(H-2){1'b0}}, r_mid_p3[WIDTH+1:H]};
    assign w_mag   = {w_upper, r_mid_p3[H-1:0], r_llo_p3};
    assign w_prod  = apply_sign(w_mag, r_neg_p3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_neg_p1    <= 1'b0;
            r_tag_p1    <= '0;
            r_a_p1      <= '0;
            r_b_p1      <= '0;
            r_vld_p2    <= 1'b0;
            r_neg_p2    <= 1'b0;
            r_tag_p2    <= '0;
            r_ll_p2     <= '0;
            r_hl_p2     <= '0;
            r_lh_p2     <= '0;
            r_hh_p2     <= '0;
            r_vld_p3    <= 1'b0;
            r_neg_p3    <= 1'b0;
            r_tag_p3    <= '0;
            r_mid_p3    <= '0;
            r_llo_p3    <= '0;
            r_hh_p3     <= '0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_tag   <= '0;
        end else if (w_adv) begin
            // stage 1: operand magnitudes and result sign
            r_vld_p1    <= in_valid;
            r_neg_p1    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            r_tag_p1    <= in_tag;
            r_a_p1      <= abs_mag(in_a, in_signed);
            r_b_p1      <= abs_mag(in_b, in_signed);
            // stage 2: four half-width quadrant products
            r_vld_p2    <= r_vld_p1;
            r_neg_p2    <= r_neg_p1;
            r_tag_p2    <= r_tag_p1;
            r_ll_p2     <= w_ll;
            r_hl_p2     <= w_hl;
            r_lh_p2     <= w_lh;
            r_hh_p2     <= w_hh;
            // stage 3: crosswise middle sum
            r_vld_p3    <= r_vld_p2;
            r_neg_p3    <= r_neg_p2;
            r_tag_p3    <= r_tag_p2;
            r_mid_p3    <= w_mid;
            r_llo_p3    <= r_ll_p2[H-1:0];
            r_hh_p3     <= r_hh_p2;
            // stage 4: final assembly and sign restore
            r_out_valid <= r_vld_p3;
            r_out_p     <= w_prod;
            r_out_tag   <= r_tag_p3;
        end
    end

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed and scoreboarded bench for vedic_mul_pipe at WIDTH=32.
module tb_vedic_mul_pipe;

    localparam int W  = 32;
    localparam int TW = 4;

    typedef struct packed {
        logic [2*W-1:0] p;
        logic [TW-1:0]  tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_signed;
    logic [TW-1:0]  in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic [TW-1:0]  out_tag;

    exp_t           sb_q[$];
    logic [2*W-1:0] exp_in;
    int             n_vec = 0;
    int             n_err = 0;
    int             rdy_mode = 0;
    int             bp_cyc = 0;

    vedic_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // One clock: choose out_ready, sample handshakes before the edge, score after it.
    task automatic step(output bit acc);
        bit             hs;
        bit             stall;
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
        exp_t           e;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1: begin
                out_ready = (bp_cyc >= 5 && bp_cyc <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
                bp_cyc++;
            end
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        acc   = in_valid && in_ready;
        hs    = out_valid && out_ready;
        stall = out_valid && !out_ready;
        p     = out_p;
        t     = out_tag;
        if (acc) sb_q.push_back('{exp_in, in_tag});
        @(posedge clk);
        #1;
        if (hs) begin
            chk_eq("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_eq("prod", p, e.p);
                chk_eq("tag", t, e.tag);
            end
        end
        if (stall) begin
            chk_eq("stall_p", out_p, p);
            chk_eq("stall_tag", out_tag, t);
            chk_eq("stall_rdy", in_ready, 0);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input logic [TW-1:0] tg, input logic [2*W-1:0] e);
        bit acc = 1'b0;
        int n = 0;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tg;
        exp_in    = e;
        in_valid  = 1'b1;
        while (!acc && n < 50) begin
            step(acc);
            n++;
        end
        chk_eq("accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        bit acc;
        int n = 0;
        in_valid = 1'b0;
        while (sb_q.size() > 0 && n < max_cyc) begin
            step(acc);
            n++;
        end
        chk_eq("drain", sb_q.size(), 0);
    endtask

    localparam int ND = 12;
    logic [W-1:0]   dv_a [ND] = '{32'd3, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h80000000,
                                  32'h80000000, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    logic [W-1:0]   dv_b [ND] = '{32'd5, 32'hFFFFFFFF, 32'h9ABCDEF1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                  32'd1, 32'hFFFFFFFD, 32'h80000000, 32'd2, 32'd2, 32'h10};
    bit             dv_s [ND] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0};
    logic [2*W-1:0] dv_p [ND] = '{64'd15, 64'hFFFFFFFE00000001, 64'h0, 64'h0, 64'h1, 64'h4000000000000000,
                                  64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFEB, 64'h4000000000000000,
                                  64'hFFFFFFFFFFFFFFFE, 64'h1FFFFFFFE, 64'h123456780};

    initial begin
        bit           acc;
        int           cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'd3;
        in_b      = 32'd5;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        exp_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_vld", out_valid, 0);
        chk_eq("rst_rdy", in_ready, 1);
        chk_eq("rst_p", out_p, 0);
        chk_eq("rst_tag", out_tag, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Accept edge counts as cycle 1; the product is visible after the fourth edge.
        in_a = 32'd3; in_b = 32'd5; in_signed = 1'b0; in_tag = 4'h1; exp_in = 64'd15;
        in_valid = 1'b1;
        step(acc);
        chk_eq("lat_acc", acc, 1);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            step(acc);
            cnt++;
        end
        chk_eq("latency", cnt, 4);
        drain(20);

        for (int i = 0; i < ND; i++) send(dv_a[i], dv_b[i], dv_s[i], TW'(i), dv_p[i]);
        drain(40);

        rdy_mode = 1;
        bp_cyc   = 0;
        for (int i = 0; i < 10; i++) send(W'(i + 1), W'(i + 3), 1'b0, TW'(i), 64'((i + 1) * (i + 3)));
        drain(200);

        rdy_mode = 2;
        send(32'd11, 32'd13, 1'b0, 4'h1, 64'd143);
        send(32'd17, 32'd19, 1'b0, 4'h2, 64'd323);
        send(32'd23, 32'd29, 1'b0, 4'h3, 64'd667);
        step(acc);
        chk_eq("mr_vld_pre", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mr_vld", out_valid, 0);
        chk_eq("mr_rdy", in_ready, 1);
        chk_eq("mr_p", out_p, 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        repeat (6) step(acc);
        chk_eq("mr_idle", out_valid, 0);
        send(32'h1234, 32'h10, 1'b0, 4'h9, 64'h12340);
        drain(20);

        rdy_mode = 3;
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) step(acc);
            send(ra, rb, rs, TW'(i), ref_mul(ra, rb, rs));
        end
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
